// File: rtl/min_hour_counter.sv
// min_hour_counter: minute/hour stage of the digital clock.
// The minute field advances on the edge where the seconds counter wraps 59 -> 0.
// The hour field advances when the minute field also wraps.
// day_carry flags the 23:59:59 -> 00:00:00 edge for the calendar stage.
// Optional build macro MIN_HOUR_12H_EN selects a 12-hour display (hr 1..12 plus pm).
// Without it, hr shows 0..23 and pm is tied low.
// Internal state is always kept in 24-hour form, so counting and carries are the
// same in both builds.
module min_hour_counter (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic [5:0]  sec,
  input  logic        load_min,
  input  logic        load_hr,
  input  logic [5:0]  data,
  input  logic        enable,
  output logic [5:0]  min,
  output logic [4:0]  hr,
  output logic        pm,
  output logic        day_carry,
  output logic [11:0] databus
);

`ifdef MIN_HOUR_12H_EN
  localparam logic [4:0] HR_RESET = 5'd12;  // midnight reads as 12 AM
`else
  localparam logic [4:0] HR_RESET = 5'd0;
`endif

  logic [5:0]  min_reg, min_next;
  logic [4:0]  hr_reg, hr_next;
  logic [4:0]  hr_disp_reg, hr_disp_next;
  logic        pm_reg, pm_next;
  logic        sec_c, min_c, any_load;
  logic [11:0] bus_word;

  // Carry chain: seconds at 59 with counting enabled, then minutes at 59.
  // A seconds value of 60..63 never compares equal to 59, so it produces no carry.
  assign sec_c     = run & (sec == 6'd59);
  assign min_c     = sec_c & (min_reg == 6'd59);
  assign any_load  = load_min | load_hr;
  assign day_carry = min_c & (hr_reg == 5'd23) & ~load_min & ~load_hr & ~clear;

  // Next 24-hour state: a load beats counting, and a loaded field is clamped to 0 when out of range.
  always_comb begin
    min_next = min_reg;
    hr_next  = hr_reg;
    if (any_load) begin
      if (load_min) min_next = (data < 6'd60) ? data : 6'd0;
      if (load_hr)  hr_next  = (data[4:0] < 5'd24) ? data[4:0] : 5'd0;
    end else if (sec_c) begin
      min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
      if (min_c) hr_next = (hr_reg == 5'd23) ? 5'd0 : hr_reg + 5'd1;
    end
  end

  // Display encoding is computed from the next state, so hr and pm stay registered and change together with the count.
  always_comb begin
`ifdef MIN_HOUR_12H_EN
    if (hr_next == 5'd0)       hr_disp_next = 5'd12;
    else if (hr_next > 5'd12)  hr_disp_next = hr_next - 5'd12;
    else                       hr_disp_next = hr_next;
    pm_next = (hr_next >= 5'd12);
`else
    hr_disp_next = hr_next;
    pm_next      = 1'b0;
`endif
  end

  // State and display registers; clear takes priority over loads and counting.
  always_ff @(posedge clk) begin
    if (clear) begin
      min_reg     <= 6'd0;
      hr_reg      <= 5'd0;
      hr_disp_reg <= HR_RESET;
      pm_reg      <= 1'b0;
    end else begin
      min_reg     <= min_next;
      hr_reg      <= hr_next;
      hr_disp_reg <= hr_disp_next;
      pm_reg      <= pm_next;
    end
  end

  assign min      = min_reg;
  assign hr       = hr_disp_reg;
  assign pm       = pm_reg;
  assign bus_word = {pm_reg, hr_disp_reg, min_reg};

  // Each bus bit is gated by enable; the bus reads 0 when enable is low.
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_bus
      assign databus[gi] = enable & bus_word[gi];
    end
  endgenerate

endmodule

// File: tb/tb_min_hour_counter.sv
// tb_min_hour_counter: directed scenarios followed by randomized traffic.
// Results are compared against a reference that tracks time as minutes since midnight.
module tb_min_hour_counter;

  logic        clk = 1'b0;
  logic        clear, run, load_min, load_hr, enable;
  logic [5:0]  sec, data;
  logic [5:0]  min;
  logic [4:0]  hr;
  logic        pm, day_carry;
  logic [11:0] databus;

  int checks = 0;
  int errors = 0;
  int t_ref  = 0;   // reference time: minutes since midnight, 0..1439

  always #5 clk = ~clk;

  min_hour_counter dut (
    .clk(clk), .clear(clear), .run(run), .sec(sec),
    .load_min(load_min), .load_hr(load_hr), .data(data), .enable(enable),
    .min(min), .hr(hr), .pm(pm), .day_carry(day_carry), .databus(databus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int disp_hr(input int h);
`ifdef MIN_HOUR_12H_EN
    return (h % 12 == 0) ? 12 : h % 12;
`else
    return h;
`endif
  endfunction

  function automatic int disp_pm(input int h);
`ifdef MIN_HOUR_12H_EN
    return (h >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One transaction: drive inputs, check combinational outputs mid-cycle,
  // advance the reference on the edge, then check registered outputs.
  task automatic step(input bit c, input bit r, input int s, input bit lm,
                      input bit lh, input int d, input bit en);
    int h, m, exp_dc, exp_bus;
    bit sc;
    clear = c; run = r; sec = s[5:0]; load_min = lm; load_hr = lh;
    data = d[5:0]; enable = en;
    #3;
    sc = r && (s == 59);
    h = t_ref / 60;
    m = t_ref % 60;
    exp_dc  = (!c && !lm && !lh && sc && t_ref == 1439) ? 1 : 0;
    exp_bus = en ? ((disp_pm(h) << 11) | (disp_hr(h) << 6) | m) : 0;
    check("day_carry", int'(day_carry), exp_dc);
    check("databus", int'(databus), exp_bus);
    @(posedge clk);
    if (c) t_ref = 0;
    else if (lm || lh) begin
      if (lm) m = (d < 60) ? d : 0;
      if (lh) h = ((d % 32) < 24) ? d % 32 : 0;
      t_ref = h * 60 + m;
    end else if (sc) t_ref = (t_ref + 1) % 1440;
    #1;
    h = t_ref / 60;
    m = t_ref % 60;
    check("min", int'(min), m);
    check("hr", int'(hr), disp_hr(h));
    check("pm", int'(pm), disp_pm(h));
    $display("txn clr=%0b run=%0b sec=%0d lm=%0b lh=%0b d=%0d en=%0b -> %0d:%02d pm=%0b dc_prev=%0b bus=%h",
             c, r, s, lm, lh, d, en, hr, min, pm, exp_dc, databus);
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; sec = '0; load_min = 1'b0; load_hr = 1'b0;
    data = '0; enable = 1'b0;
    @(posedge clk); #1;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Rollover: load 00:58, count two full minutes of seconds
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 58, 1);
    for (int k = 0; k < 120; k++) step(0, 1, k % 60, 0, 0, 0, 1);

    // Day wrap from 23:59:59
    step(0, 0, 0, 0, 1, 23, 1);
    step(0, 0, 0, 1, 0, 59, 1);
    step(0, 1, 59, 0, 0, 0, 1);

    // Load priority over a pending carry
    step(0, 0, 0, 0, 1, 23, 1);
    step(0, 0, 0, 1, 0, 59, 1);
    step(0, 1, 59, 1, 0, 7, 1);

    // Range clamps, both loads together, out-of-range sec
    step(0, 0, 0, 0, 1, 30, 1);
    step(0, 0, 0, 1, 0, 63, 1);
    step(0, 0, 0, 1, 1, 20, 1);
    step(0, 1, 60, 0, 0, 0, 1);
    step(0, 1, 63, 0, 0, 0, 1);

    // Gating: run low with sec 59, then enable toggling at 13:45
    step(0, 0, 0, 0, 1, 13, 1);
    step(0, 0, 0, 1, 0, 45, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 59, 0, 0, 0, k % 2);

    // Reset mid-carry at 23:59:59
    step(0, 0, 0, 0, 1, 23, 1);
    step(0, 0, 0, 1, 0, 59, 1);
    step(1, 1, 59, 1, 1, 5, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit c, r, lm, lh, en;
      int s, d;
      c  = ($urandom_range(0, 49) == 0);
      r  = ($urandom_range(0, 7) != 0);
      lm = ($urandom_range(0, 15) == 0);
      lh = ($urandom_range(0, 15) == 0);
      en = $urandom_range(0, 1);
      s  = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 63));
      d  = $urandom_range(0, 63);
      // occasionally steer toward 23:59 to exercise day wrap
      if ($urandom_range(0, 31) == 0) begin
        step(0, 0, 0, 0, 1, 23, en);
        step(0, 0, 0, 1, 0, 59, en);
      end
      step(c, r, s, lm, lh, d, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
